life_plot_scheduler: RTL and testbench

Top-level sequencer for the Game of Life display path. It owns the single `vga_adapter` write port (`x`, `y`, `colour`, `plot`) and drives it from three sources in turn:
- a power-on/requested screen clear,
- user cell loads,
- cell-change plots from the simulation engine.

It also paces generations with a programmable tick timer or a manual step, and counts completed generations.

---
 rtl/life_plot_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_life_plot_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/life_plot_scheduler.sv
// life_plot_scheduler: sequences the vga_adapter write port between screen clear, user loads and engine plots.
// Optional simulation watchdog enabled by defining LIFE_SCHED_WATCHDOG_EN.
module life_plot_scheduler #(
    parameter int X_MAX         = 160,
    parameter int Y_MAX         = 120,
    parameter int TICKS_PER_GEN = 12500000,
    parameter int WDOG_CYCLES   = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        step,
    input  logic        clear_req,
    input  logic        load_req,
    input  logic [7:0]  load_x,
    input  logic [6:0]  load_y,
    output logic        load_ack,
    output logic        sim_start,
    input  logic        sim_done,
    input  logic        sim_req,
    input  logic [7:0]  sim_x,
    input  logic [6:0]  sim_y,
    input  logic [2:0]  sim_colour,
    output logic        sim_ack,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        clearing,
    output logic [15:0] gen_count,
    output logic        sim_timeout
);
    typedef enum logic [1:0] {CLEAR, IDLE, START, WAIT_SIM} state_t;

    localparam logic [7:0]  XM = 8'(X_MAX);
    localparam logic [7:0]  XL = 8'(X_MAX - 1);
    localparam logic [7:0]  YM = 8'(Y_MAX);
    localparam logic [31:0] TL = 32'(TICKS_PER_GEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  sx_q, sx_d, sy_q, sy_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d, load_ack_q, load_ack_d, sim_ack_q, sim_ack_d, sim_start_q, sim_start_d;
    logic [15:0] gen_q, gen_d;
    logic [31:0] timer_q, timer_d;
`ifdef LIFE_SCHED_WATCHDOG_EN
    localparam logic [31:0] WL = 32'(WDOG_CYCLES - 1);
    logic [31:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        x_d         = x_q;
        y_d         = y_q;
        colour_d    = colour_q;
        plot_d      = 1'b0;
        load_ack_d  = 1'b0;
        sim_ack_d   = 1'b0;
        sim_start_d = 1'b0;
        gen_d       = gen_q;
        timer_d     = '0;
`ifdef LIFE_SCHED_WATCHDOG_EN
        wdog_d      = '0;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            CLEAR: begin
                // sy reaching Y_MAX marks the sweep as finished
                if (sy_q == YM) begin
                    state_d = IDLE;
                end else begin
                    plot_d   = 1'b1;
                    x_d      = sx_q;
                    y_d      = sy_q[6:0];
                    colour_d = 3'b000;
                    sx_d     = (sx_q == XL) ? 8'd0 : sx_q + 8'd1;
                    sy_d     = (sx_q == XL) ? sy_q + 8'd1 : sy_q;
                end
            end
            IDLE: begin
                timer_d = run ? timer_q + 32'd1 : 32'd0;
                if (load_req && !load_ack_q) begin
                    load_ack_d = 1'b1;
                    plot_d     = (load_x < XM) && ({1'b0, load_y} < YM);
                    x_d        = load_x;
                    y_d        = load_y;
                    colour_d   = 3'b111;
                end
                if (clear_req) begin
                    state_d = CLEAR;
                    sx_d    = '0;
                    sy_d    = '0;
                    timer_d = '0;
                end else if ((run && timer_q == TL) || (step && !run)) begin
                    state_d = START;
                    timer_d = '0;
                end
            end
            START: begin
                sim_start_d = 1'b1;
                state_d     = WAIT_SIM;
            end
            WAIT_SIM: begin
                if (sim_req && !sim_ack_q) begin
                    sim_ack_d = 1'b1;
                    plot_d    = 1'b1;
                    x_d       = sim_x;
                    y_d       = sim_y;
                    colour_d  = sim_colour;
                end else if (sim_done && !sim_req) begin
                    state_d = IDLE;
                    gen_d   = gen_q + 16'd1;
                end
`ifdef LIFE_SCHED_WATCHDOG_EN
                wdog_d = wdog_q + 32'd1;
                if (wdog_q == WL && state_d == WAIT_SIM) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            sx_q        <= '0;
            sy_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            plot_q      <= 1'b0;
            load_ack_q  <= 1'b0;
            sim_ack_q   <= 1'b0;
            sim_start_q <= 1'b0;
            gen_q       <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            plot_q      <= plot_d;
            load_ack_q  <= load_ack_d;
            sim_ack_q   <= sim_ack_d;
            sim_start_q <= sim_start_d;
            gen_q       <= gen_d;
            timer_q     <= timer_d;
        end
    end

`ifdef LIFE_SCHED_WATCHDOG_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end
    assign sim_timeout = timeout_q;
`else
    assign sim_timeout = 1'b0;
`endif

    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign load_ack  = load_ack_q;
    assign sim_ack   = sim_ack_q;
    assign sim_start = sim_start_q;
    assign clearing  = (state_q == CLEAR);
    assign gen_count = gen_q;
endmodule

// File: tb/tb_life_plot_scheduler.sv
// tb_life_plot_scheduler: directed checks of clear sweep, loads, engine plots, pacing and wrap.
module tb_life_plot_scheduler;
    logic        clock = 1'b0, reset_n = 1'b0, run = 1'b0, step = 1'b0, clear_req = 1'b0;
    logic        load_req = 1'b0, sim_done = 1'b0, sim_req = 1'b0;
    logic [7:0]  load_x = '0, sim_x = '0;
    logic [6:0]  load_y = '0, sim_y = '0;
    logic [2:0]  sim_colour = '0;
    logic        load_ack, sim_start, sim_ack, plot, clearing, sim_timeout;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic [15:0] gen_count;
    int          checks = 0, errors = 0;
    int          n;

    always #5 clock = ~clock;

    life_plot_scheduler #(
        .X_MAX(160), .Y_MAX(120), .TICKS_PER_GEN(8), .WDOG_CYCLES(50)
    ) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .step(step), .clear_req(clear_req),
        .load_req(load_req), .load_x(load_x), .load_y(load_y), .load_ack(load_ack),
        .sim_start(sim_start), .sim_done(sim_done), .sim_req(sim_req), .sim_x(sim_x),
        .sim_y(sim_y), .sim_colour(sim_colour), .sim_ack(sim_ack), .x(x), .y(y),
        .colour(colour), .plot(plot), .clearing(clearing), .gen_count(gen_count),
        .sim_timeout(sim_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset();
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_colour", 32'(colour), 0);
        check("rst_plot", 32'(plot), 0);
        check("rst_load_ack", 32'(load_ack), 0);
        check("rst_sim_ack", 32'(sim_ack), 0);
        check("rst_sim_start", 32'(sim_start), 0);
        check("rst_clearing", 32'(clearing), 1);
        check("rst_gen", 32'(gen_count), 0);
        check("rst_timeout", 32'(sim_timeout), 0);
    endtask

    task automatic run_sweep();
        int bad, ex, ey;
        bad = 0;
        ex = 0;
        ey = 0;
        for (int i = 0; i < 19200; i++) begin
            tick();
            if (i == 0) begin
                check("sweep_first_plot", 32'(plot), 1);
                check("sweep_first_clearing", 32'(clearing), 1);
            end
            if (plot !== 1'b1 || colour !== 3'd0 || clearing !== 1'b1 ||
                32'(x) != ex || 32'(y) != ey) bad++;
            ex = (ex == 159) ? 0 : ex + 1;
            if (ex == 0) ey++;
        end
        check("sweep_bad_pixels", 32'(bad), 0);
        check("sweep_last_x", 32'(x), 159);
        check("sweep_last_y", 32'(y), 119);
        tick();
        check("sweep_end_plot", 32'(plot), 0);
        check("sweep_end_clearing", 32'(clearing), 0);
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_lat1", 32'(sim_start), 0);
        tick();
        check("step_start", 32'(sim_start), 1);
    endtask

    task automatic sim_pixel(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        sim_req = 1'b1;
        sim_x = px;
        sim_y = py;
        sim_colour = pc;
        tick();
        check("sim_ack", 32'(sim_ack), 1);
        check("sim_plot", 32'(plot), 1);
        check("sim_xyc", {21'd0, x, y, colour}, {21'd0, px, py, pc});
        check("sim_load_stall", 32'(load_ack), 0);
        sim_req = 1'b0;
        tick();
        check("sim_ack_drop", 32'(sim_ack), 0);
        check("sim_plot_drop", 32'(plot), 0);
    endtask

    task automatic wait_start(output int cnt);
        cnt = 0;
        while (sim_start !== 1'b1 && cnt < 100) begin
            tick();
            step = 1'b0;
            cnt++;
        end
    endtask

    initial begin
        tick();
        tick();
        check_reset();
        reset_n = 1'b1;
        run_sweep();

        load_req = 1'b1;
        load_x = 8'd10;
        load_y = 7'd20;
        tick();
        check("load_ack", 32'(load_ack), 1);
        check("load_plot", 32'(plot), 1);
        check("load_xyc", {21'd0, x, y, colour}, {21'd0, 8'd10, 7'd20, 3'd7});
        load_req = 1'b0;
        tick();
        check("load_ack_drop", 32'(load_ack), 0);
        load_req = 1'b1;
        load_x = 8'd200;
        load_y = 7'd5;
        tick();
        check("load_oor_ack", 32'(load_ack), 1);
        check("load_oor_plot", 32'(plot), 0);
        load_req = 1'b0;
        tick();

        do_step();
        load_req = 1'b1;
        load_x = 8'd10;
        load_y = 7'd20;
        sim_pixel(8'd5, 7'd6, 3'd1);
        sim_pixel(8'd7, 7'd8, 3'd2);
        sim_req = 1'b1;
        sim_x = 8'd9;
        sim_y = 7'd10;
        sim_colour = 3'd4;
        sim_done = 1'b1;
        tick();
        check("race_ack", 32'(sim_ack), 1);
        check("race_xyc", {21'd0, x, y, colour}, {21'd0, 8'd9, 7'd10, 3'd4});
        check("race_gen_hold", 32'(gen_count), 0);
        sim_req = 1'b0;
        tick();
        check("race_gen", 32'(gen_count), 1);
        check("race_load_stall", 32'(load_ack), 0);
        sim_done = 1'b0;
        tick();
        check("load_after_sim", 32'(load_ack), 1);
        check("load_after_xyc", {21'd0, x, y, colour}, {21'd0, 8'd10, 7'd20, 3'd7});
        load_req = 1'b0;
        tick();

        run = 1'b1;
        for (int g = 0; g < 3; g++) begin
            if (g == 1) step = 1'b1;
            wait_start(n);
            check("run_latency", 32'(n), 9);
            sim_done = 1'b1;
            tick();
            sim_done = 1'b0;
            check("run_gen", 32'(gen_count), 32'(g + 2));
        end
        run = 1'b0;
        tick();

        do_step();
        sim_req = 1'b1;
        sim_x = 8'd1;
        sim_y = 7'd2;
        sim_colour = 3'd5;
        tick();
        check("pre_rst_ack", 32'(sim_ack), 1);
        reset_n = 1'b0;
        sim_req = 1'b0;
        tick();
        check_reset();
        reset_n = 1'b1;
        run_sweep();

        force dut.gen_q = 16'hffff;
        tick();
        release dut.gen_q;
        tick();
        check("gen_forced", 32'(gen_count), 65535);
        do_step();
        sim_done = 1'b1;
        tick();
        sim_done = 1'b0;
        check("gen_wrap", 32'(gen_count), 0);

`ifdef LIFE_SCHED_WATCHDOG_EN
        do_step();
        n = 0;
        while (sim_timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("wdog_cycles", 32'(n), 50);
        check("wdog_gen", 32'(gen_count), 0);
        tick();
        check("wdog_pulse", 32'(sim_timeout), 0);
        do_step();
        sim_done = 1'b1;
        tick();
        sim_done = 1'b0;
        check("wdog_idle_gen", 32'(gen_count), 1);
`endif

        run = 1'b1;
        repeat (7) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clr_win_clearing", 32'(clearing), 1);
        tick();
        check("clr_win_no_start", 32'(sim_start), 0);
        check("clr_first_plot", 32'(plot), 1);
        check("clr_first_xy", {17'd0, x, y}, 0);
        tick();
        check("clr_second_xy", {17'd0, x, y}, {17'd0, 8'd1, 7'd0});
        run = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
